qtable_update_sched: RTL
========================

# qtable_update_sched

Sequencer and ingress buffer in front of the Q-table update engine (`QTableUpdatev3`). Received packets arrive on a valid/ready interface and are queued in a small FIFO. Each queued packet is presented to the engine on stable `f*` lines with a one-cycle `en` pulse; the block then waits for `done` or a watchdog timeout before issuing the next packet. Malformed packet types are filtered, and drops, timeouts and table occupancy are reported to node control.

## Interface
- `WORD_WIDTH`, 16: width of all packet fields.
- `FIFO_DEPTH`, 4: packet queue entries (power of 2, ≥2).
- `TIMEOUT`, 64: max cycles in WAIT before abort.
- `MAX_NEIGHBORS`, 32: neighbor table capacity.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pkt_valid`  in  1  packet offered.
- `pkt_ready`  out  1  packet accepted when `pkt_valid & pkt_ready`.
- `pkt_sourceID`, `pkt_sourceHops`, `pkt_clusterID`, `pkt_energyLeft`, `pkt_qValue`, `pkt_knownCH`  in  WORD_WIDTH each  packet fields.
- `pkt_type`  in  3  packet type.
- `en`  out  1  one-cycle start pulse to the engine.
- `fSourceID`, `fSourceHops`, `fClusterID`, `fEnergyLeft`, `fQValue`, `fKnownCH`  out  WORD_WIDTH each  fields to the engine, registered.
- `fPacketType`  out  3  type to the engine, registered.
- `done`  in  1  engine completion.
- `neighborCount`  in  WORD_WIDTH  current table occupancy from the engine.
- `busy`  out  1  high in any state other than IDLE.
- `table_full`  out  1  registered flag, `neighborCount >= MAX_NEIGHBORS`.
- `timeout_err`  out  1  sticky; set on watchdog expiry.
- `drop_count`  out  8  saturating count of dropped packets.

## Operation
- Reset values: all outputs 0, FIFO empty, state IDLE, counters 0. Exception: `pkt_ready` = 1 one cycle after reset deasserts; it is 0 while `rst` is high.
- `pkt_ready = !fifo_full`. A push while the FIFO is full is not possible. Simultaneous pop does not free the slot in the same cycle.
- Filter: an accepted packet with `pkt_type` 3'b000 or 3'b111 is dropped. It is not queued, and `drop_count` increments, saturating at 255. All other types are queued.
- FSM states:
  - IDLE: if FIFO non-empty, go to LOAD.
  - LOAD: pop the head into the `f*` registers, go to START.
  - START: `en` = 1 for this cycle only, clear watchdog, go to WAIT.
  - WAIT: if `done` = 1, go to COOL. Otherwise, when the watchdog reaches TIMEOUT−1, set `timeout_err` and go to COOL. Otherwise increment the watchdog.
  - COOL: one settle cycle for the engine's memory write, go to IDLE.
- `done` outside WAIT is ignored.
- `f*` outputs change only on the LOAD edge and hold their values through START, WAIT, COOL and IDLE.
- `table_full` is informational only; packets are still dispatched, and the engine decides update versus insert.
- `timeout_err` clears only on `rst`.
- Asynchronous `rst` mid-operation:
  - `en` drops immediately and the state returns to IDLE.
  - FIFO contents are discarded and `f*` outputs are zeroed.
  - `drop_count` and `timeout_err` are cleared.

## Timing
- Packet accepted at edge N into an empty FIFO with the FSM in IDLE:
  - LOAD at edge N+1.
  - `f*` outputs valid and `en` high from edge N+2 to N+3.
  - WAIT from edge N+3.
- `done` sampled high at edge M in WAIT gives COOL at M and IDLE at M+1. The next queued packet loads at M+2, so the minimum spacing between `en` pulses is 5 cycles.
- Timeout: `en` at cycle S gives `timeout_err` = 1 at edge S+1+TIMEOUT, and `busy` stays high through the following COOL cycle.
- `table_full` lags `neighborCount` by 1 cycle.
- FIFO push-to-head latency is 1 cycle. Throughput is limited by the engine, not by the FIFO.

## Test plan
- Single packet (sourceID 1, hops 2, cluster 2, energy 16'h8000, qValue 16'h3000, type 3'b101), with `done` returned 10 cycles after `en`:
  - exactly one `en` pulse, 2 cycles after acceptance;
  - `f*` outputs equal the packet fields;
  - `busy` falls 2 cycles after `done`.
- Burst of 6 packets with `done` withheld:
  - `pkt_ready` falls after 5 accepts (4 queued plus 1 loaded);
  - on each `done`, the next packet is issued in order; `en` pulses are ≥5 cycles apart.
- Packets of type 3'b000 and 3'b111 interleaved with type 3'b101:
  - only the 3'b101 packets reach the engine;
  - `drop_count` = 2.
  - 300 invalid packets: `drop_count` saturates at 255.
- Never assert `done`:
  - `timeout_err` = 1 exactly TIMEOUT+1 cycles after `en`;
  - the next queued packet is still dispatched;
  - `timeout_err` remains 1.
- `neighborCount` stepped 31 → 32 → 31:
  - `table_full` goes 0 → 1 → 0, each change 1 cycle later.
- `rst` pulsed mid-WAIT with 3 packets queued:
  - `en`, `busy` and the `f*` outputs go to 0 asynchronously;
  - a `done` pulse after reset triggers nothing;
  - a new packet dispatches normally.

Source files
------------

// File: rtl/qtable_update_sched.sv
// Ingress FIFO and dispatch sequencer for the Q-table update engine.
// Filters malformed packet types and reports drops, timeouts and table occupancy.
module qtable_update_sched #(
  parameter int unsigned WORD_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned MAX_NEIGHBORS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [WORD_WIDTH-1:0] pkt_sourceID,
  input  logic [WORD_WIDTH-1:0] pkt_sourceHops,
  input  logic [WORD_WIDTH-1:0] pkt_clusterID,
  input  logic [WORD_WIDTH-1:0] pkt_energyLeft,
  input  logic [WORD_WIDTH-1:0] pkt_qValue,
  input  logic [WORD_WIDTH-1:0] pkt_knownCH,
  input  logic [2:0]            pkt_type,
  output logic                  en,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fClusterID,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fKnownCH,
  output logic [2:0]            fPacketType,
  input  logic                  done,
  input  logic [WORD_WIDTH-1:0] neighborCount,
  output logic                  busy,
  output logic                  table_full,
  output logic                  timeout_err,
  output logic [7:0]            drop_count
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PktW = 6 * WORD_WIDTH + 3;
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [WdW-1:0]        WdLast    = WdW'(TIMEOUT - 1);
  localparam logic [WdW-1:0]        WdOne     = WdW'(1);
  localparam logic [AW:0]           PtrOne    = (AW + 1)'(1);
  localparam logic [WORD_WIDTH-1:0] FullLevel = WORD_WIDTH'(MAX_NEIGHBORS);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StCool} state_e;

  state_e          state_q, state_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [PktW-1:0] mem_q [FIFO_DEPTH];
  logic [PktW-1:0] f_pkt_q;
  logic [PktW-1:0] pkt_in;
  logic            ready_q;
  logic            timeout_err_q;
  logic            table_full_q;
  logic [7:0]      drop_q;
  logic            set_timeout;

  logic fifo_empty, fifo_full, accept, bad_type, push, pop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // ready_q holds pkt_ready low until the first clock after reset release.
  assign pkt_ready = ready_q & ~fifo_full;
  assign accept    = pkt_valid & pkt_ready;
  assign bad_type  = (pkt_type == 3'b000) | (pkt_type == 3'b111);
  assign push      = accept & ~bad_type;
  assign pop       = (state_q == StLoad);

  assign pkt_in = {pkt_sourceID, pkt_sourceHops, pkt_clusterID, pkt_energyLeft,
                   pkt_qValue, pkt_knownCH, pkt_type};

  assign {fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH,
          fPacketType} = f_pkt_q;

  assign en          = (state_q == StStart);
  assign busy        = (state_q != StIdle);
  assign table_full  = table_full_q;
  assign timeout_err = timeout_err_q;
  assign drop_count  = drop_q;

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    set_timeout = 1'b0;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StLoad;
      StLoad:  state_d = StStart;
      StStart: begin
        state_d = StWait;
        wdog_d  = '0;
      end
      StWait: begin
        if (done) begin
          state_d = StCool;
        end else if (wdog_q == WdLast) begin
          set_timeout = 1'b1;
          state_d     = StCool;
        end else begin
          wdog_d = wdog_q + WdOne;
        end
      end
      StCool:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      wdog_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      f_pkt_q       <= '0;
      ready_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      table_full_q  <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      ready_q      <= 1'b1;
      table_full_q <= (neighborCount >= FullLevel);
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
        f_pkt_q  <= mem_q[rd_ptr_q[AW-1:0]];
      end
      if (set_timeout) timeout_err_q <= 1'b1;
      if (accept && bad_type && (drop_q != 8'hff)) drop_q <= drop_q + 8'd1;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= pkt_in;
  end

endmodule
